// File: rtl/psa_pipe.sv
// ---------------------------------------------------------------------------
// psa_pipe
//   Two-stage pipelined SIMD (sub-word) adder/subtractor. The WIDTH-bit
//   operands are split into NL = WIDTH/LANE independent two's-complement
//   lanes. Each lane is added or subtracted with a saturating or wrapping
//   result. Every lane reports overflow in both modes, and a sticky copy
//   of that overflow accumulates per lane.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   in_valid/ready  operand handshake (in_ready does not depend on in_valid)
//   a, b            operands; lane i occupies [i*LANE +: LANE]
//   op              bit0: 0 = add, 1 = a-b; bit1: 0 = saturate, 1 = wrap
//   out_valid/ready result handshake
//   sum, ovf        lane-wise result and per-lane overflow of that result
//   clr_sticky      one-cycle pulse that clears ovf_sticky
//   ovf_sticky      per-lane OR of ovf over all delivered beats
// ---------------------------------------------------------------------------
module psa_pipe #(
  parameter  int WIDTH = 16,
  parameter  int LANE  = 4,
  localparam int NL    = WIDTH / LANE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [NL-1:0]    ovf,
  input  logic             clr_sticky,
  output logic [NL-1:0]    ovf_sticky
);

  generate
    if (((WIDTH % LANE) != 0) || (LANE < 2)) begin : g_bad_cfg
      $error("psa_pipe: WIDTH must be a multiple of LANE and LANE must be >= 2");
    end
  endgenerate

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_op_q, s1_op_d;

  // Stage 2: registered result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [NL-1:0]    ovf_q, ovf_d;
  logic [NL-1:0]    sticky_q, sticky_d;

  logic             s1_en, s2_en, out_hs;
  logic [WIDTH-1:0] lane_sum;
  logic [NL-1:0]    lane_ovf;

  // A stage may load when it is empty or when its content moves on this
  // cycle; this lets bubbles collapse and keeps in_valid out of in_ready.
  always_comb begin
    s2_en  = ~s2_valid_q | out_ready;
    s1_en  = ~s1_valid_q | s2_en;
    out_hs = s2_valid_q & out_ready;
  end

  assign in_ready   = s1_en;
  assign out_valid  = s2_valid_q;
  assign sum        = sum_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

  // Lane datapath. Each lane has its own adder, so no carry or borrow
  // crosses a lane boundary. Subtraction is a + ~b + 1.
  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      logic [LANE-1:0] la, lb, lbp, raw, sat_val;
      logic            lovf;

      assign la      = s1_a_q[gi*LANE +: LANE];
      assign lb      = s1_b_q[gi*LANE +: LANE];
      assign lbp     = s1_op_q[0] ? ~lb : lb;
      assign raw     = la + lbp + {{(LANE-1){1'b0}}, s1_op_q[0]};
      // Overflow: both addends share a sign and the result sign differs.
      assign lovf    = (la[LANE-1] == lbp[LANE-1]) && (raw[LANE-1] != la[LANE-1]);
      // Clamp toward the sign of A: most negative or most positive value.
      assign sat_val = la[LANE-1] ? {1'b1, {(LANE-1){1'b0}}}
                                  : {1'b0, {(LANE-1){1'b1}}};

      assign lane_sum[gi*LANE +: LANE] = (lovf && !s1_op_q[1]) ? sat_val : raw;
      assign lane_ovf[gi]              = lovf;
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      // Operands are sampled only on a real handshake.
      if (in_valid) begin
        s1_a_d  = a;
        s1_b_d  = b;
        s1_op_d = op;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d = lane_sum;
        ovf_d = lane_ovf;
      end
    end
  end

  // A clear that coincides with a delivered beat leaves exactly that
  // beat's overflow bits set.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (out_hs) begin
      sticky_d = sticky_d | ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      ovf_q      <= '0;
      sticky_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_psa_pipe.sv
module tb_psa_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [15:0] a, b, sum;
  logic [1:0]  op;
  logic [3:0]  ovf, ovf_sticky;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, clr8;
  logic [15:0] a8, b8, sum8;
  logic [1:0]  op8;
  logic [1:0]  ovf8, sticky8;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  ovf;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] sum;
    logic [3:0]  ovf;
  } vec_t;

  vec_t stream_tbl[8] = '{
    '{16'h1234, 16'h1111, 2'b00, 16'h2345, 4'h0},
    '{16'h0000, 16'h0001, 2'b00, 16'h0001, 4'h0},
    '{16'h5555, 16'h1111, 2'b01, 16'h4444, 4'h0},
    '{16'h7777, 16'h1111, 2'b00, 16'h7777, 4'hF},
    '{16'h7777, 16'h1111, 2'b10, 16'h8888, 4'hF},
    '{16'h8888, 16'h1111, 2'b01, 16'h8888, 4'hF},
    '{16'h8888, 16'h1111, 2'b11, 16'h7777, 4'hF},
    '{16'hFFFF, 16'h0001, 2'b00, 16'hFFF0, 4'h0}
  };

  psa_pipe #(.WIDTH(16), .LANE(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );

  psa_pipe #(.WIDTH(16), .LANE(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .ovf(ovf8),
    .clr_sticky(clr8), .ovf_sticky(sticky8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one beat from the negedge and hold it until accepted.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic [1:0] vop,
                      input logic [15:0] es, input logic [3:0] eo, input bit push);
    bit rdy;
    bit done;
    done = 0;
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb; op = vop;
    for (int t = 0; t < 50; t++) begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        if (push) sb_q.push_back('{es, eo});
        $display("send a=%h b=%h op=%b exp sum=%h ovf=%b", va, vb, vop, es, eo);
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // Scoreboard monitor: compare every delivered beat with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("recv sum=%h ovf=%b (exp %h %b)", sum, ovf, e.sum, e.ovf);
          chk("beat_sum", sum, e.sum);
          chk("beat_ovf", ovf, e.ovf);
        end
        rx_cnt++;
      end
    end
  end

  initial begin
    logic [15:0] held;
    rst = 1'b1; in_valid = 0; a = 0; b = 0; op = 0; out_ready = 1'b1; clr_sticky = 0;
    in_valid8 = 0; a8 = 0; b8 = 0; op8 = 0; out_ready8 = 1'b1; clr8 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst = 1'b0;

    // Add-sat with latency check
    send(16'h7F81, 16'h1111, 2'b00, 16'h7092, 4'b1000, 1);
    idle();
    #1 chk("lat_early", out_valid, 0);
    @(negedge clk);
    #1 chk("lat_on_time", out_valid, 1);
    drain();

    // Sub-sat and sub-wrap
    send(16'h8000, 16'h1000, 2'b01, 16'h8000, 4'b1000, 1);
    send(16'h8000, 16'h1000, 2'b11, 16'h7000, 4'b1000, 1);
    idle();
    drain();

    // Streaming with a mid-stream stall
    rx_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(stream_tbl[i].a, stream_tbl[i].b, stream_tbl[i].op,
               stream_tbl[i].sum, stream_tbl[i].ovf, 1);
        idle();
      end
      begin
        for (int t = 0; t < 50 && rx_cnt < 2; t++) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1 held = sum;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          #1;
          chk("stall_sum_hold", sum, held);
          chk("stall_valid_hold", out_valid, 1);
          if (k == 1) chk("stall_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int t = 0; t < 40 && rx_cnt < 8; t++) begin
          #1 chk("release_throughput", out_valid, 1);
          @(negedge clk);
        end
      end
    join
    drain();
    chk("stream_count", rx_cnt, 8);

    // Sticky sequence
    @(negedge clk); clr_sticky = 1'b1;
    @(negedge clk); clr_sticky = 1'b0;
    #1 chk("sticky_cleared", ovf_sticky, 0);
    send(16'h7000, 16'h1000, 2'b00, 16'h7000, 4'b1000, 1);
    idle();
    @(negedge clk);
    @(negedge clk);
    #1 chk("sticky_lane3", ovf_sticky, 4'b1000);
    send(16'h0007, 16'h0001, 2'b00, 16'h0007, 4'b0001, 1);
    idle();
    @(negedge clk);
    clr_sticky = 1'b1;
    #1 chk("clr_coincide_valid", out_valid, 1);
    @(negedge clk);
    clr_sticky = 1'b0;
    #1 chk("sticky_clr_set_wins", ovf_sticky, 4'b0001);
    drain();

    // Asynchronous reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h7777, 16'h1111, 2'b00, 16'h7777, 4'hF, 0);
    send(16'h1234, 16'h1111, 2'b00, 16'h2345, 4'h0, 0);
    idle();
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sticky", ovf_sticky, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(16'h1234, 16'h1111, 2'b00, 16'h2345, 4'h0, 1);
    idle();
    #1 chk("post_rst_lat_early", out_valid, 0);
    @(negedge clk);
    #1 chk("post_rst_lat_on_time", out_valid, 1);
    drain();

    // LANE = 8 configuration
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 16'h7F80; b8 = 16'h0101; op8 = 2'b00;
    #1 chk("l8_in_ready", in_ready8, 1);
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int t = 0; t < 10 && !out_valid8; t++) begin
      #1;
      if (!out_valid8) @(negedge clk);
    end
    #1;
    $display("l8 recv sum=%h ovf=%b", sum8, ovf8);
    chk("l8_valid", out_valid8, 1);
    chk("l8_sum", sum8, 16'h7F81);
    chk("l8_ovf", ovf8, 2'b10);
    @(negedge clk);
    #1 chk("l8_sticky", sticky8, 2'b10);

    chk("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
